scratch_arbiter: RTL and testbench

Shares the single-ported convolution scratchpad between up to NUM_REQ requesters: the controller's filter/pixel loader, the output-writeback unit, and the host fill DMA. Grants whole bursts with round-robin fairness and a hard burst cap. Issues one memory access per accepted beat and routes read data back to the issuing requester after the fixed memory latency. Sits between the requesters and the scratchpad macro.

---
 rtl/scratch_arb_pkg.sv | 19 +
 rtl/scratch_arbiter_if.sv | 32 +++
 rtl/scratch_arbiter_rr_pick.sv | 25 ++
 rtl/scratch_arbiter.sv | 156 +++++++++++++++
 tb/tb_scratch_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/scratch_arb_pkg.sv
// Shared types and defaults for the convolution scratchpad arbiter.
package scratch_arb_pkg;

  typedef enum logic [0:0] {
    ARB   = 1'b0,
    OWNED = 1'b1
  } arb_state_e;

  localparam int REQ_LOADER = 0;
  localparam int REQ_WB     = 1;
  localparam int REQ_HOST   = 2;

  localparam int DEF_NUM_REQ   = 3;
  localparam int DEF_ADDR_W    = 20;
  localparam int DEF_DATA_W    = 32;
  localparam int DEF_MEM_LAT   = 2;
  localparam int DEF_MAX_BURST = 16;

endpackage

// File: rtl/scratch_arbiter_if.sv
// Requester and scratchpad port bundle; slave is the arbiter's view, master the environment's.
interface scratch_arbiter_if
  import scratch_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W
);
  logic [NUM_REQ-1:0]             req;
  logic [NUM_REQ-1:0]             req_we;
  logic [NUM_REQ-1:0]             req_last;
  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]             gnt;
  logic [NUM_REQ-1:0]             rsp_valid;
  logic [DATA_W-1:0]              rsp_data;
  logic                           mem_en;
  logic                           mem_we;
  logic [ADDR_W-1:0]              mem_addr;
  logic [DATA_W-1:0]              mem_wdata;
  logic [DATA_W-1:0]              mem_rdata;

  modport master (
    output req, req_we, req_last, req_addr, req_wdata, mem_rdata,
    input  gnt, rsp_valid, rsp_data, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  req, req_we, req_last, req_addr, req_wdata, mem_rdata,
    output gnt, rsp_valid, rsp_data, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/scratch_arbiter_rr_pick.sv
// Combinational round-robin picker: first pending requester after last_owner, with wrap.
module rr_pick
  import scratch_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IDX_W   = $clog2(DEF_NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_owner,
  output logic [IDX_W-1:0]   winner,
  output logic               any_req
);

  // Walk candidates last_owner+1 .. last_owner+NUM_REQ; the first hit sticks.
  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      winner  = (!any_req && req[(int'(last_owner) + i) % NUM_REQ])
              ? IDX_W'((int'(last_owner) + i) % NUM_REQ) : winner;
      any_req = any_req | req[(int'(last_owner) + i) % NUM_REQ];
    end
  end

endmodule

// File: rtl/scratch_arbiter.sv
// Scratchpad arbiter: round-robin burst ownership, one access per accepted beat,
// and a latency-matched tag pipe that steers read data back to the issuing requester.
module scratch_arbiter
  import scratch_arb_pkg::*;
#(
  parameter int NUM_REQ   = DEF_NUM_REQ,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MEM_LAT   = DEF_MEM_LAT,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic             clk,
  input  logic             rst_n,
  scratch_arbiter_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  arb_state_e         state_r, state_s;
  logic [IDX_W-1:0]   owner_r, owner_s;
  logic [IDX_W-1:0]   last_owner_r, last_owner_s;
  logic [IDX_W-1:0]   winner_s;
  logic [CNT_W-1:0]   beat_cnt_r, beat_cnt_s;
  logic               any_req_s;
  logic               accept_s;
  logic [NUM_REQ-1:0] gnt_s;

  logic               mem_en_s;
  logic               mem_we_s;
  logic [ADDR_W-1:0]  mem_addr_s;
  logic [DATA_W-1:0]  mem_wdata_s;

  logic               tag_vld_r [MEM_LAT];
  logic [IDX_W-1:0]   tag_idx_r [MEM_LAT];
  logic [NUM_REQ-1:0] rsp_valid_s;
  logic [DATA_W-1:0]  rsp_data_s;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req        (bus.req),
    .last_owner (last_owner_r),
    .winner     (winner_s),
    .any_req    (any_req_s)
  );

  assign accept_s = (state_r == OWNED) && bus.req[owner_r];

  // FSM state, ownership and burst counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ARB;
      owner_r      <= '0;
      last_owner_r <= IDX_W'(NUM_REQ - 1);
      beat_cnt_r   <= '0;
    end else begin
      state_r      <= state_s;
      owner_r      <= owner_s;
      last_owner_r <= last_owner_s;
      beat_cnt_r   <= beat_cnt_s;
    end
  end

  // Next-state and grant: ARB picks an owner, OWNED streams beats until last, cap or abandon.
  always_comb begin
    state_s      = state_r;
    owner_s      = owner_r;
    last_owner_s = last_owner_r;
    beat_cnt_s   = beat_cnt_r;
    gnt_s        = '0;
    case (state_r)
      ARB: begin
        if (any_req_s) begin
          state_s    = OWNED;
          owner_s    = winner_s;
          beat_cnt_s = '0;
        end else begin
          state_s = ARB;
        end
      end
      OWNED: begin
        if (bus.req[owner_r]) begin
          gnt_s[owner_r] = 1'b1;
          beat_cnt_s     = beat_cnt_r + CNT_W'(1);
          // Counter is compared before increment so the cap beat itself forces release.
          if (bus.req_last[owner_r] || (beat_cnt_r == CNT_W'(MAX_BURST - 1))) begin
            state_s      = ARB;
            last_owner_s = owner_r;
          end else begin
            state_s = OWNED;
          end
        end else begin
          state_s      = ARB;
          last_owner_s = owner_r;
        end
      end
      default: begin
        state_s = ARB;
      end
    endcase
  end

  // Memory port mux: owner's beat goes straight to the macro in the accepting cycle.
  always_comb begin
    mem_en_s    = 1'b0;
    mem_we_s    = 1'b0;
    mem_addr_s  = '0;
    mem_wdata_s = '0;
    if (accept_s) begin
      mem_en_s    = 1'b1;
      mem_we_s    = bus.req_we[owner_r];
      mem_addr_s  = bus.req_addr[owner_r];
      mem_wdata_s = bus.req_wdata[owner_r];
    end else begin
      mem_en_s    = 1'b0;
    end
  end

  // Read tag pipe, aligned so its last stage coincides with valid mem_rdata.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < MEM_LAT; k++) begin
        tag_vld_r[k] <= 1'b0;
        tag_idx_r[k] <= '0;
      end
    end else begin
      tag_vld_r[0] <= accept_s && !bus.req_we[owner_r];
      tag_idx_r[0] <= owner_r;
      for (int k = 1; k < MEM_LAT; k++) begin
        tag_vld_r[k] <= tag_vld_r[k-1];
        tag_idx_r[k] <= tag_idx_r[k-1];
      end
    end
  end

  // Response decode; rsp_data is held at zero when no read is returning.
  always_comb begin
    rsp_valid_s = '0;
    rsp_data_s  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rsp_valid_s[i] = tag_vld_r[MEM_LAT-1] && (tag_idx_r[MEM_LAT-1] == IDX_W'(i));
    end
    rsp_data_s = tag_vld_r[MEM_LAT-1] ? bus.mem_rdata : '0;
  end

  assign bus.gnt       = gnt_s;
  assign bus.mem_en    = mem_en_s;
  assign bus.mem_we    = mem_we_s;
  assign bus.mem_addr  = mem_addr_s;
  assign bus.mem_wdata = mem_wdata_s;
  assign bus.rsp_valid = rsp_valid_s;
  assign bus.rsp_data  = rsp_data_s;

endmodule

// File: tb/tb_scratch_arbiter.sv
// Bench: three arbiter copies (MEM_LAT 1, 2, 4) on shared stimulus, checked against a behavioural model.
module tb_scratch_arbiter;
  import scratch_arb_pkg::*;

  localparam int NREQ = 3;
  localparam int AW   = 20;
  localparam int DW   = 32;
  localparam int MAXB = 16;
  localparam int NL   = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NREQ-1:0]         req, req_we, req_last;
  logic [NREQ-1:0][AW-1:0] req_addr;
  logic [NREQ-1:0][DW-1:0] req_wdata;

  logic [NREQ-1:0] gnt_a       [NL];
  logic [NREQ-1:0] rsp_valid_a [NL];
  logic [DW-1:0]   rsp_data_a  [NL];
  logic            mem_en_a    [NL];
  logic            mem_we_a    [NL];
  logic [AW-1:0]   mem_addr_a  [NL];
  logic [DW-1:0]   mem_wdata_a [NL];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  function automatic int lat_of(input int l);
    return (l == 0) ? 1 : ((l == 1) ? 2 : 4);
  endfunction

  // Power-on content of every scratchpad word.
  function automatic logic [DW-1:0] pre(input int a);
    return 32'hC0DE_0000 | 32'(a & 1023);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, want, cyc);
    end
  endtask

  for (genvar g = 0; g < NL; g++) begin : lane
    localparam int L = (g == 0) ? 1 : ((g == 1) ? 2 : 4);
    scratch_arbiter_if #(.NUM_REQ(NREQ), .ADDR_W(AW), .DATA_W(DW)) bus ();
    logic [DW-1:0] smem  [1024];
    logic [1023:0] wflag = '0;
    logic [DW-1:0] rpipe [L];

    assign bus.req       = req;
    assign bus.req_we    = req_we;
    assign bus.req_last  = req_last;
    assign bus.req_addr  = req_addr;
    assign bus.req_wdata = req_wdata;
    assign bus.mem_rdata = rpipe[L-1];
    assign gnt_a[g]       = bus.gnt;
    assign rsp_valid_a[g] = bus.rsp_valid;
    assign rsp_data_a[g]  = bus.rsp_data;
    assign mem_en_a[g]    = bus.mem_en;
    assign mem_we_a[g]    = bus.mem_we;
    assign mem_addr_a[g]  = bus.mem_addr;
    assign mem_wdata_a[g] = bus.mem_wdata;

    // Scratchpad macro model with an L-cycle read pipe.
    always @(posedge clk) begin
      if (bus.mem_en && bus.mem_we) begin
        smem[bus.mem_addr[9:0]]  <= bus.mem_wdata;
        wflag[bus.mem_addr[9:0]] <= 1'b1;
      end
      rpipe[0] <= (bus.mem_en && !bus.mem_we)
                ? (wflag[bus.mem_addr[9:0]] ? smem[bus.mem_addr[9:0]] : pre(int'(bus.mem_addr[9:0])))
                : 32'hDEAD_BEEF;
      for (int k = 1; k < L; k++) rpipe[k] <= rpipe[k-1];
    end

    scratch_arbiter #(
      .NUM_REQ(NREQ), .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(L), .MAX_BURST(MAXB)
    ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
    );
  end

  // ---------------- behavioural reference model ----------------
  typedef struct { int due; int idx; logic [DW-1:0] data; } exp_t;
  exp_t expq [NL][$];
  int m_owner = -1;           // -1: next cycle is an arbitration cycle
  int m_last  = NREQ - 1;
  int m_beats = 0;
  logic [DW-1:0] ref_mem [1024];
  logic [1023:0] ref_wr = '0;

  task automatic step();
    logic [NREQ-1:0] eg, ev;
    logic            een, ewe;
    logic [AW-1:0]   ea;
    logic [DW-1:0]   ed, edat;
    int              o;
    eg = '0; een = 1'b0; ewe = 1'b0; ea = '0; ed = '0;
    if (!rst_n) begin
      for (int l = 0; l < NL; l++) begin
        chk("rst_gnt", gnt_a[l], 0);
        chk("rst_rsp_valid", rsp_valid_a[l], 0);
        chk("rst_rsp_data", rsp_data_a[l], 0);
        chk("rst_mem_en", mem_en_a[l], 0);
        chk("rst_mem_we", mem_we_a[l], 0);
        chk("rst_mem_addr", mem_addr_a[l], 0);
        chk("rst_mem_wdata", mem_wdata_a[l], 0);
        expq[l].delete();
      end
      m_owner = -1; m_last = NREQ - 1; m_beats = 0;
    end else begin
      for (int l = 0; l < NL; l++) begin
        ev = '0; edat = '0;
        if (expq[l].size() > 0 && expq[l][0].due == cyc) begin
          ev[expq[l][0].idx] = 1'b1;
          edat = expq[l][0].data;
          void'(expq[l].pop_front());
        end
        chk("rsp_valid", rsp_valid_a[l], ev);
        if (ev != 0) chk("rsp_data", rsp_data_a[l], edat);
      end
      if (m_owner < 0) begin
        for (int k = 1; k <= NREQ; k++) begin
          if (m_owner < 0 && req[(m_last + k) % NREQ]) m_owner = (m_last + k) % NREQ;
        end
        m_beats = 0;
      end else begin
        o = m_owner;
        if (req[o]) begin
          eg[o] = 1'b1; een = 1'b1; ewe = req_we[o]; ea = req_addr[o]; ed = req_wdata[o];
          m_beats++;
          if (ewe) begin
            ref_mem[ea[9:0]] = ed;
            ref_wr[ea[9:0]]  = 1'b1;
          end else begin
            for (int l = 0; l < NL; l++)
              expq[l].push_back('{cyc + lat_of(l), o, ref_wr[ea[9:0]] ? ref_mem[ea[9:0]] : pre(int'(ea[9:0]))});
          end
          if (req_last[o] || m_beats == MAXB) begin m_last = o; m_owner = -1; end
        end else begin
          m_last = o; m_owner = -1;
        end
      end
      for (int l = 0; l < NL; l++) begin
        chk("gnt", gnt_a[l], eg);
        chk("mem_en", mem_en_a[l], een);
        if (een) begin
          chk("mem_we", mem_we_a[l], ewe);
          chk("mem_addr", mem_addr_a[l], ea);
          if (ewe) chk("mem_wdata", mem_wdata_a[l], ed);
        end
      end
    end
    cyc++;
  endtask

  initial forever begin
    @(negedge clk);
    step();
  end

  // Log of responses seen on the MEM_LAT=2 copy.
  typedef struct { int idx; logic [DW-1:0] data; } rsp_t;
  rsp_t rsp_log [$];
  initial forever begin
    @(negedge clk);
    for (int i = 0; i < NREQ; i++)
      if (rsp_valid_a[1][i]) rsp_log.push_back('{i, rsp_data_a[1]});
  end

  // ---------------- directed sequences ----------------
  typedef struct { logic [NREQ-1:0] rq; logic [NREQ-1:0] lst; logic [NREQ-1:0] gnt; } vec_t;

  task automatic run_table();
    vec_t tbl [13];
    logic [NREQ-1:0] want;
    int b, idx;
    tbl[0]  = '{3'b111, 3'b000, 3'b000};
    tbl[1]  = '{3'b111, 3'b000, 3'b001};
    tbl[2]  = '{3'b111, 3'b111, 3'b001};
    tbl[3]  = '{3'b110, 3'b000, 3'b000};
    tbl[4]  = '{3'b110, 3'b000, 3'b010};
    tbl[5]  = '{3'b110, 3'b111, 3'b010};
    tbl[6]  = '{3'b100, 3'b000, 3'b000};
    tbl[7]  = '{3'b100, 3'b000, 3'b100};
    tbl[8]  = '{3'b100, 3'b111, 3'b100};
    tbl[9]  = '{3'b000, 3'b000, 3'b000};
    tbl[10] = '{3'b000, 3'b000, 3'b000};
    tbl[11] = '{3'b000, 3'b000, 3'b000};
    tbl[12] = '{3'b000, 3'b000, 3'b000};
    for (int r = 0; r < 13; r++) begin
      @(posedge clk); #1;
      req = tbl[r].rq; req_last = tbl[r].lst; req_we = '0;
      for (int i = 0; i < NREQ; i++) begin
        req_addr[i]  = AW'(32'h100 + 16 * i + r);
        req_wdata[i] = '0;
      end
      #3;
      chk("tbl_gnt", gnt_a[1], tbl[r].gnt);
      for (int l = 0; l < NL; l++) begin
        b    = r - lat_of(l);
        want = (b >= 0) ? tbl[b].gnt : 3'b000;
        chk("tbl_rsp_valid", rsp_valid_a[l], want);
        if (want != 0) begin
          idx = want[0] ? 0 : (want[1] ? 1 : 2);
          chk("tbl_rsp_data", rsp_data_a[l], pre(32'h100 + 16 * idx + b));
        end
      end
    end
  endtask

  task automatic run_cut();
    int n1 = 0, got2 = 0, ord[$];
    for (int c = 0; c < 80 && (n1 < 20 || got2 == 0); c++) begin
      @(posedge clk); #1;
      req = '0; req_last = '0; req_we = '0;
      req[1] = (n1 < 20); req_we[1] = 1'b1; req_last[1] = (n1 == 19);
      req_addr[1] = AW'(32'h200 + n1); req_wdata[1] = 32'hA000_0000 + 32'(n1);
      req[2] = (got2 == 0); req_we[2] = 1'b1; req_last[2] = 1'b1;
      req_addr[2] = AW'(32'h2F0); req_wdata[2] = 32'hB0B0_0002;
      #3;
      if (gnt_a[1][1]) begin ord.push_back(1); n1++; end
      if (gnt_a[1][2]) begin ord.push_back(2); got2++; end
    end
    @(posedge clk); #1 req = '0;
    chk("cut_beats_total", ord.size(), 21);
    for (int i = 0; i < ord.size() && i < 21; i++)
      chk("cut_order", ord[i], (i == 16) ? 2 : 1);
  endtask

  task automatic run_abandon();
    int n = 0, n0 = 0;
    rsp_log.delete();
    for (int c = 0; c < 20 && n < 3; c++) begin
      @(posedge clk); #1;
      req = 3'b001; req_we = '0; req_last = '0; req_addr[0] = AW'(32'h300 + n);
      #3;
      if (gnt_a[1][0]) n++;
    end
    chk("abandon_beats", n, 3);
    @(posedge clk); #1 req = '0;
    #3 chk("abandon_gnt", gnt_a[1], 0);
    @(posedge clk); #1 req = 3'b001; req_last = 3'b001; req_addr[0] = AW'(32'h310);
    #3 chk("abandon_arb_cycle", gnt_a[1], 0);
    @(posedge clk); #4 chk("abandon_regrant", gnt_a[1], 3'b001);
    @(posedge clk); #1 req = '0; req_last = '0;
    repeat (5) @(posedge clk);
    foreach (rsp_log[i]) if (rsp_log[i].idx == 0) n0++;
    chk("abandon_rsp_count", rsp_log.size(), 4);
    chk("abandon_rsp_owner", n0, 4);
  endtask

  task automatic one_beat(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic done = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(posedge clk); #1;
      req = '0; req_we = '0; req_last = '0;
      req[i] = 1'b1; req_we[i] = we; req_last[i] = 1'b1; req_addr[i] = a; req_wdata[i] = d;
      #3 done = gnt_a[1][i];
    end
    @(posedge clk); #1 req = '0;
    chk("beat_accepted", done, 1);
  endtask

  task automatic run_rw();
    rsp_log.delete();
    one_beat(0, 1'b0, AW'(32'h10), '0);
    one_beat(1, 1'b1, AW'(32'h10), 32'h5EED_0010);
    one_beat(0, 1'b0, AW'(32'h10), '0);
    repeat (6) @(posedge clk);
    chk("rw_rsp_count", rsp_log.size(), 2);
    if (rsp_log.size() == 2) begin
      chk("rw_old_data", rsp_log[0].data, pre(32'h10));
      chk("rw_new_data", rsp_log[1].data, 32'h5EED_0010);
      chk("rw_owner", rsp_log[1].idx, 0);
    end
  endtask

  task automatic run_reset();
    int n = 0, k;
    for (int c = 0; c < 20 && n < 2; c++) begin
      @(posedge clk); #1;
      req = 3'b001; req_we = '0; req_last = '0; req_addr[0] = AW'(32'h320 + n);
      #3;
      if (gnt_a[1][0]) n++;
    end
    chk("reset_reads_accepted", n, 2);
    @(posedge clk); #1 rst_n = 1'b0; req = '0;
    k = rsp_log.size();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    chk("reset_no_rsp", rsp_log.size() - k, 0);
    #1 req = 3'b111; req_last = 3'b111; req_we = '0;
    #3 chk("reset_arb_cycle", gnt_a[1], 0);
    @(posedge clk); #4 chk("reset_first_winner", gnt_a[1], 3'b001);
    @(posedge clk); #1 req = '0; req_last = '0;
  endtask

  task automatic run_random();
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      rst_n = ($urandom_range(0, 399) != 0);
      for (int i = 0; i < NREQ; i++) begin
        req[i]       = ($urandom_range(0, 9) < 9);
        req_we[i]    = 1'($urandom_range(0, 1));
        req_last[i]  = ($urandom_range(0, 19) == 0);
        req_addr[i]  = AW'($urandom_range(0, 63));
        req_wdata[i] = $urandom;
      end
    end
    @(posedge clk); #1 rst_n = 1'b1; req = '0;
  endtask

  initial begin
    req = '0; req_we = '0; req_last = '0; req_addr = '0; req_wdata = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    run_table();
    run_cut();
    run_abandon();
    run_rw();
    run_reset();
    run_random();
    repeat (8) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
